// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide engine:
// FSM state encoding, default iteration counts, the divide-by-zero
// quotient constant and a small absolute-value helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIV_ITERS_DEFAULT = 32;
    localparam int MUL_ITERS_DEFAULT = 32;

    // Quotient returned when the divisor is zero.
    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    // Magnitude of a 32-bit operand; only negative values of signed operands are flipped.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_sign);
        return (is_sign && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step. The 64-bit partial remainder holds
// the running remainder in the upper half and the not-yet-consumed dividend
// bits (shifting out) / produced quotient bits (shifting in) in the lower half.
module div_step (
    input  logic [63:0] rem_i,
    input  logic [31:0] divisor_i,
    output logic [63:0] rem_o,
    output logic        q_bit_o
);

    logic [31:0] sub;

    // Shift left by one, try subtracting the divisor from the upper 33 bits, keep it if non-negative.
    always_comb begin
        // The shifted upper half is 33 bits wide; compare on all of them so
        // divisors with bit 31 set are handled.
        q_bit_o = (rem_i[63:31] >= {1'b0, divisor_i});
        // When the subtraction is kept the true difference is below the
        // divisor, so its low 32 bits are the whole result.
        sub     = rem_i[62:31] - divisor_i;
        if (q_bit_o) begin
            rem_o = {sub, rem_i[30:0], 1'b1};
        end else begin
            rem_o = {rem_i[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multi-cycle multiply/divide engine producing {hi,lo} for
// the hilo register. Division is restoring radix-2, one quotient bit per
// cycle. Multiply is a single registered 64-bit product by default; when
// MULDIV_ITER_MUL_EN is defined it becomes a MUL_ITERS-cycle shift-add
// multiplier with identical results.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT,
    parameter int MUL_ITERS = MUL_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic        mulOrdivE,
    input  logic        mdIsSignE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        flushE,
    output logic        md_stallE,
    output logic        md_doneE,
    output logic [31:0] md_hiE,
    output logic [31:0] md_loE
);

    localparam int ITER_MAX = (DIV_ITERS > MUL_ITERS) ? DIV_ITERS : MUL_ITERS;
    localparam int CNT_W    = $clog2(ITER_MAX) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);
`ifdef MULDIV_ITER_MUL_EN
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        rem_q, rem_d;      // partial remainder, or multiplier/product
    logic [31:0]        dvsr_q, dvsr_d;    // divisor magnitude, or multiplicand magnitude
    logic [31:0]        raw_a_q, raw_a_d;  // unmodified dividend for divide-by-zero
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               div0_q, div0_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        step_rem;
    logic               step_q;

    logic [31:0]        a_abs, b_abs;
    logic [31:0]        q_raw, r_raw;
    logic [63:0]        fin;

    div_step u_div_step (
        .rem_i     (rem_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

`ifdef MULDIV_ITER_MUL_EN
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    // Shift-add step: add the multiplicand into the upper half when the current multiplier bit is set, then shift right.
    always_comb begin
        mul_sum  = {1'b0, rem_q[63:32]} + (rem_q[0] ? {1'b0, dvsr_q} : 33'd0);
        mul_next = {mul_sum, rem_q[31:1]};
    end
`else
    logic [63:0] prod;

    // Full 64-bit product of the operand magnitudes, sign applied on the way into DONE.
    assign prod = {32'd0, dvsr_q} * {32'd0, rem_q[31:0]};
`endif

    // Next-state, datapath updates and result capture with the sign fix-up.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        raw_a_d = raw_a_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        fin     = 64'd0;
        a_abs   = abs32(srcaE, mdIsSignE);
        b_abs   = abs32(srcbE, mdIsSignE);
        q_raw   = {step_rem[31:1], step_q};
        r_raw   = step_rem[63:32];

        unique case (state_q)
            IDLE: begin
                if (startE && !flushE) begin
                    cnt_d   = '0;
                    negq_d  = mdIsSignE & (srcaE[31] ^ srcbE[31]);
                    negr_d  = mdIsSignE & srcaE[31];
                    div0_d  = (srcbE == 32'd0);
                    raw_a_d = srcaE;
                    if (mulOrdivE) begin
                        rem_d   = {32'd0, a_abs};
                        dvsr_d  = b_abs;
                        state_d = DIV;
                    end else begin
                        rem_d   = {32'd0, b_abs};
                        dvsr_d  = a_abs;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (flushE) begin
                    state_d = IDLE;
                end else begin
`ifdef MULDIV_ITER_MUL_EN
                    rem_d = mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == MUL_LAST) begin
                        fin     = negq_q ? (~mul_next + 64'd1) : mul_next;
                        hi_d    = fin[63:32];
                        lo_d    = fin[31:0];
                        state_d = DONE;
                    end
`else
                    fin     = negq_q ? (~prod + 64'd1) : prod;
                    hi_d    = fin[63:32];
                    lo_d    = fin[31:0];
                    state_d = DONE;
`endif
                end
            end
            DIV: begin
                if (flushE) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) begin
                        // A zero divisor still runs every step; its result is replaced here.
                        if (div0_q) begin
                            lo_d = DIV_BY_ZERO_LO;
                            hi_d = raw_a_q;
                        end else begin
                            lo_d = negq_q ? (~q_raw + 32'd1) : q_raw;
                            hi_d = negr_q ? (~r_raw + 32'd1) : r_raw;
                        end
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // The finishing instruction is still in E, so startE is not a new request here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= 64'd0;
            dvsr_q  <= 32'd0;
            raw_a_q <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            raw_a_q <= raw_a_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall covers the start cycle and the busy states; a flush silences both stall and done.
    always_comb begin
        md_stallE = !flushE && ((state_q == IDLE && startE) || state_q == MUL || state_q == DIV);
        md_doneE  = !flushE && (state_q == DONE);
        md_hiE    = hi_q;
        md_loE    = lo_q;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Execute-stage multi-cycle multiply/divide engine that consumes the controller's E-stage mdToHiloE / mulOrdivE / mdIsSignE decode. It produces the 64-bit {hi,lo} result that the M-stage hilo register writes when mdToHiloM is set. It raises a stall for the hazard unit while an operation is in flight. Division uses an iterative restoring radix-2 datapath.

Parameters:
- DIV_ITERS, 32, quotient bits produced; one per iteration cycle.
- MUL_ITERS, 32, iteration count for the iterative multiplier; only used when the Optional Feature macro is defined.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- startE  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU (mdToHiloE)
- mulOrdivE  in  1  0 = multiply, 1 = divide
- mdIsSignE  in  1  1 = signed operands
- srcaE  in  32  rs operand (dividend / multiplicand)
- srcbE  in  32  rt operand (divisor / multiplier)
- flushE  in  1  annul the in-flight operation (exception / eret)
- md_stallE  out  1  hold F/D/E stages
- md_doneE  out  1  result valid this cycle
- md_hiE  out  32  remainder / product[63:32]
- md_loE  out  32  quotient / product[31:0]

Behaviour:
- Reset (async, any state): state=IDLE; md_doneE=0; md_hiE=md_loE=0; all internal registers are cleared.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE & startE & ~flushE:
  - Latch the operands. For signed operations, latch absolute values, negq=sign(a)^sign(b) and negr=sign(a).
  - Go to DIV if mulOrdivE=1, otherwise MUL.
- md_stallE = (IDLE & startE & ~flushE) | MUL | DIV. The stall is combinational and rises in the start cycle.
- DIV: one restoring step per cycle, with a 64-bit partial remainder shifted left 1. If the trial subtraction is >=0, keep it and shift in a quotient bit of 1.
  - After DIV_ITERS cycles, go to DONE.
  - Sign fix at the transition into DONE: quotient negated if negq, remainder negated if negr.
- Divide by zero: detected at start. Still takes the full DIV_ITERS cycles. Result lo=32'hFFFF_FFFF, hi=srcaE (raw, unsigned/signed alike). No exception is raised.
- 0x8000_0000 / -1 (signed): lo=0x8000_0000, hi=0 (natural wrap). No exception.
- MUL (macro off): 1 cycle. Result = full 64-bit signed or unsigned product of the latched operands, then go to DONE.
- DONE:
  - md_doneE=1 and md_stallE=0 for exactly one cycle; the E->M register captures the result.
  - startE is ignored in DONE, because the same instruction is still in E.
  - Next state is IDLE.
- md_hiE and md_loE hold their last value until the next DONE.
- Latency from the start cycle to the md_doneE cycle: DIV = DIV_ITERS+1 = 33; MUL = 2 (macro off).
- flushE in MUL/DIV/DONE: go to IDLE next cycle. md_doneE is forced 0 in the flush cycle. md_hiE/md_loE are unchanged. md_stallE is forced 0 while flushE=1.
- flushE together with startE in IDLE: no start.

Optional Feature:
- MULDIV_ITER_MUL_EN defined: MUL becomes a shift-add multiplier over absolute values, MUL_ITERS cycles, with sign fix on exit. Multiply latency is MUL_ITERS+1 = 33.
- Not defined: a single-cycle registered 64-bit multiply, latency 2.
- Results are bit-identical in both builds.

Decomposition:
- Shared package muldiv_pkg holds:
  - the state encoding (IDLE=2'd0, MUL=2'd1, DIV=2'd2, DONE=2'd3);
  - the DIV_ITERS/MUL_ITERS defaults;
  - the divide-by-zero result constant 32'hFFFF_FFFF.
- One natural sub-module: div_step, combinational. It takes the 64-bit partial remainder and the divisor, and returns the next remainder and the quotient bit. muldiv_unit holds the FSM, the counter and the sign fix.

Test Plan:
- DIVU 100/7 -> md_stallE high for 33 cycles (start cycle included). Then md_doneE for 1 cycle with lo=14, hi=2. Then IDLE.
- DIV -7/2 signed -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). Also DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
- DIVU 5/0 -> 33-cycle latency, lo=0xFFFF_FFFF, hi=5, no hang.
- MULT 0xFFFF_FFFF * 2 signed -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFE. MULTU of the same operands -> hi=1, lo=0xFFFF_FFFE. Latency is 2 (33 with MULDIV_ITER_MUL_EN).
- flushE at DIV iteration 10 -> IDLE next cycle; no md_doneE; stall drops. A DIVU 9/3 issued next -> lo=3, hi=0.
- rst asserted mid-DIV (asynchronously, between edges) -> outputs 0 immediately. After release with startE held, a fresh operation starts and the counter restarts from 0.
